// File: rtl/axi4_lite_adder_accel.sv
// axi4_lite_adder_accel: AXI4-Lite slave around a serial multi-word add/sub engine.
// Optional IRQ output is enabled by defining AXIL_ADDER_IRQ_EN.
module axi4_lite_adder_accel #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
`ifdef AXIL_ADDER_IRQ_EN
  ,
  output logic                    IRQ
`endif
);
  localparam int DW = DATA_WIDTH;
  localparam int NW = OP_WIDTH / DATA_WIDTH;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [31:0] A_LO = 32'd2;
  localparam logic [31:0] B_LO = A_LO + 32'(NW);
  localparam logic [31:0] S_LO = B_LO + 32'(NW);
  localparam logic [31:0] TOP  = S_LO + 32'(NW);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {R_CTRL, R_STAT, R_A, R_B, R_SUM, R_OOR} region_t;
  typedef enum logic [1:0] {IDLE, WRITE, WRESP, RDATA} bus_t;
  typedef enum logic {E_IDLE, E_RUN} eng_t;

  function automatic region_t region(input logic [31:0] i);
    region_t r;
    unique case (1'b1)
      i == 32'd0:             r = R_CTRL;
      i == 32'd1:             r = R_STAT;
      i >= A_LO && i < B_LO:  r = R_A;
      i >= B_LO && i < S_LO:  r = R_B;
      i >= S_LO && i < TOP:   r = R_SUM;
      default:                r = R_OOR;
    endcase
    return r;
  endfunction

  function automatic logic [KW-1:0] sel(input logic [31:0] i,
                                        input logic [31:0] base);
    logic [31:0] d;
    d = i - base;
    return d[KW-1:0];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0]   old,
                                          input logic [DW-1:0]   d,
                                          input logic [DW/8-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW/8; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  logic [DW-1:0] a_q   [NW];
  logic [DW-1:0] b_q   [NW];
  logic [DW-1:0] acc_q [NW];
  logic [DW-1:0] sum_q [NW];
  logic          sub_q, ie_q, done_q, carry_q, c_q;
  logic [KW-1:0] k_q;
  bus_t          bus_q, bus_d;
  eng_t          eng_q, eng_d;

  logic [31:0]   widx, ridx;
  region_t       wreg, rreg;
  logic [KW-1:0] wsa, wsb;
  logic          busy, wr_fire, wr_ok, start, last, c_n;
  logic [DW-1:0] ctrl_word, ctrl_new, a_new, b_new, rd_word, b_op, s_n;
  logic          unused;

  assign unused = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

  assign widx      = 32'(S_AWADDR[ADDRESS-1:2]);
  assign ridx      = 32'(S_ARADDR[ADDRESS-1:2]);
  assign wreg      = region(widx);
  assign rreg      = region(ridx);
  assign wsa       = sel(widx, A_LO);
  assign wsb       = sel(widx, B_LO);
  assign busy      = eng_q == E_RUN;
  assign ctrl_word = DW'({ie_q, sub_q, 1'b0});
  assign ctrl_new  = merge(ctrl_word, S_WDATA, S_WSTRB);
  assign a_new     = merge(a_q[wsa], S_WDATA, S_WSTRB);
  assign b_new     = merge(b_q[wsb], S_WDATA, S_WSTRB);
  assign wr_fire   = bus_q == WRITE;
  assign wr_ok     = wr_fire && !busy &&
                     (wreg == R_CTRL || wreg == R_A || wreg == R_B);
  assign start     = wr_ok && wreg == R_CTRL && ctrl_new[0];
  assign S_BVALID  = bus_q == WRESP;
  assign S_RVALID  = bus_q == RDATA;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) bus_q <= IDLE;
    else          bus_q <= bus_d;
  end

  // write wins over a simultaneous read request in IDLE
  always_comb begin
    bus_d     = bus_q;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_ARREADY = 1'b0;
    unique case (bus_q)
      IDLE: begin
        if (S_AWVALID && S_WVALID) begin
          bus_d = WRITE;
        end else if (S_ARVALID) begin
          S_ARREADY = 1'b1;
          bus_d     = RDATA;
        end
      end
      WRITE: begin
        S_AWREADY = 1'b1;
        S_WREADY  = 1'b1;
        bus_d     = WRESP;
      end
      WRESP:   if (S_BREADY) bus_d = IDLE;
      RDATA:   if (S_RREADY) bus_d = IDLE;
      default: bus_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NW; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      sub_q   <= 1'b0;
      ie_q    <= 1'b0;
      S_BRESP <= OKAY;
    end else if (wr_fire) begin
      S_BRESP <= wr_ok ? OKAY : SLVERR;
      if (wr_ok) begin
        unique case (wreg)
          R_CTRL: begin
            sub_q <= ctrl_new[1];
            ie_q  <= ctrl_new[2];
          end
          R_A:     a_q[wsa] <= a_new;
          R_B:     b_q[wsb] <= b_new;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_word = '0;
    unique case (rreg)
      R_CTRL:  rd_word = ctrl_word;
      R_STAT:  rd_word = DW'({carry_q, done_q, busy});
      R_A:     rd_word = a_q[sel(ridx, A_LO)];
      R_B:     rd_word = b_q[sel(ridx, B_LO)];
      R_SUM:   rd_word = sum_q[sel(ridx, S_LO)];
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_RDATA <= '0;
      S_RRESP <= OKAY;
    end else if (S_ARREADY) begin
      S_RDATA <= rd_word;
      S_RRESP <= (rreg == R_OOR) ? SLVERR : OKAY;
    end
  end

  assign last = k_q == KW'(NW - 1);
  assign b_op = sub_q ? ~b_q[k_q] : b_q[k_q];
  assign {c_n, s_n} = {1'b0, a_q[k_q]} + {1'b0, b_op} + (DW+1)'(c_q);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) eng_q <= E_IDLE;
    else          eng_q <= eng_d;
  end

  always_comb begin
    eng_d = eng_q;
    unique case (eng_q)
      E_IDLE:  if (start) eng_d = E_RUN;
      E_RUN:   if (last) eng_d = E_IDLE;
      default: eng_d = E_IDLE;
    endcase
  end

  // partial words collect in acc_q so SUM only ever shows whole results
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NW; i++) begin
        acc_q[i] <= '0;
        sum_q[i] <= '0;
      end
      k_q     <= '0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (start) begin
      k_q    <= '0;
      c_q    <= ctrl_new[1];
      done_q <= 1'b0;
    end else if (eng_q == E_RUN) begin
      acc_q[k_q] <= s_n;
      c_q        <= c_n;
      k_q        <= k_q + KW'(1);
      if (last) begin
        for (int i = 0; i < NW; i++)
          sum_q[i] <= (i == int'(k_q)) ? s_n : acc_q[i];
        carry_q <= c_n;
        done_q  <= 1'b1;
      end
    end
  end

`ifdef AXIL_ADDER_IRQ_EN
  logic irq_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)
      irq_q <= 1'b0;
    else if (start || (wr_ok && wreg == R_CTRL && !ctrl_new[2]))
      irq_q <= 1'b0;
    else
      irq_q <= done_q & ie_q;
  end

  assign IRQ = irq_q;
`endif

endmodule
